// File: rtl/x_micro_sequencer_pkg.sv
// x_micro_sequencer_pkg
//   Shared types and constants for the micro-sequencer fetch/execute engine.
//   Program word layout: {data[DATA_W-1:0], cmd[CMD_W-1:0]}.
//   Data-field slices:
//     wait count  : data[WAIT_W-1:0]
//     loop target : data[ADDR_W-1:0]   (also the JUMP target)
//     loop count  : data[ADDR_W+LOOP_W-1:ADDR_W]
package x_micro_sequencer_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 36;
    localparam int CMD_W  = 4;
    localparam int WAIT_W = 32;
    localparam int LOOP_W = 16;

    localparam int WAIT_LSB = 0;
    localparam int WAIT_MSB = WAIT_W - 1;
    localparam int TGT_LSB  = 0;
    localparam int TGT_MSB  = ADDR_W - 1;
    localparam int LOOP_LSB = ADDR_W;
    localparam int LOOP_MSB = ADDR_W + LOOP_W - 1;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP  = 4'd0,
        CMD_OUT  = 4'd1,
        CMD_WAIT = 4'd2,
        CMD_JUMP = 4'd3,
        CMD_LOOP = 4'd4,
        CMD_HALT = 4'd5,
        CMD_TRIG = 4'd6
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WAIT  = 3'd3,
        S_TRIG  = 3'd4
    } state_t;

endpackage

// File: rtl/x_micro_sequencer_timer.sv
// x_micro_sequencer_timer
//   Loadable down-counter used to time the WAIT stall.
//   Ports:
//     i_clk       clock
//     i_rst       asynchronous reset, active-low
//     i_load      load i_load_val into the counter
//     i_load_val  stall length in cycles
//     i_en        count down by one (held at zero)
//     o_done      terminal count: this is the last stall cycle
module x_micro_sequencer_timer
    import x_micro_sequencer_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [WAIT_W-1:0] i_load_val,
    input  logic              i_en,
    output logic              o_done
);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= i_load_val;
        end else if (i_en && (cnt != '0)) begin
            cnt <= cnt - WAIT_W'(1);
        end
    end

    // A load of N gives exactly N enabled cycles before done is seen,
    // because done fires while the count still reads 1.
    assign o_done = (cnt == WAIT_W'(1));

endmodule

// File: rtl/x_micro_sequencer_exec.sv
// x_micro_sequencer_exec
//   Fetch/execute engine on the read side of the micro-sequencer program RAM.
//   Walks the RAM from a start address, decodes each command and drives
//   output words, timed waits, jumps, one loop level, trigger waits and halt.
//
//   Build option: define X_MICRO_SEQ_LOOP_EN to implement the LOOP command.
//   Without it LOOP executes as NOP and no loop state exists.
//
//   Ports:
//     i_clk         clock
//     i_rst         asynchronous reset, active-low
//     i_start       start pulse, honoured in IDLE only
//     i_start_addr  first instruction address, sampled with i_start
//     i_stop        synchronous abort to IDLE, highest priority
//     i_trig        external trigger consumed by TRIG
//     o_busy        high while not in IDLE
//     o_raddr       RAM read address
//     i_rdata       RAM data field, valid the cycle after o_raddr
//     i_rcmd        RAM command field, valid the cycle after o_raddr
//     o_data        last OUT word
//     o_data_vld    one-cycle pulse when o_data updates
//
//   state | meaning
//   IDLE  | waiting for i_start
//   FETCH | o_raddr = pc, RAM read in flight
//   EXEC  | decode {i_rdata, i_rcmd}
//   WAIT  | stalling for the WAIT count
//   TRIG  | stalling until i_trig is high
module x_micro_sequencer_exec
    import x_micro_sequencer_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic              i_stop,
    input  logic              i_trig,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_raddr,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [CMD_W-1:0]  i_rcmd,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_vld
);

    state_t            state;
    state_t            state_nxt;
    cmd_t              cmd;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] tgt;
    logic [WAIT_W-1:0] wait_val;
    logic              wait_zero;
    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_done;
    logic              out_we;

`ifdef X_MICRO_SEQ_LOOP_EN
    logic [LOOP_W-1:0] loop_cnt;
    logic [LOOP_W-1:0] loop_cnt_nxt;
    logic              loop_armed;
    logic              loop_armed_nxt;
    logic [LOOP_W-1:0] loop_n;
    logic [LOOP_W-1:0] loop_dec;

    assign loop_n   = i_rdata[LOOP_MSB:LOOP_LSB];
    assign loop_dec = loop_cnt - LOOP_W'(1);
`endif

    assign cmd       = cmd_t'(i_rcmd);
    assign tgt       = i_rdata[TGT_MSB:TGT_LSB];
    assign wait_val  = i_rdata[WAIT_MSB:WAIT_LSB];
    assign wait_zero = (wait_val == '0);
    assign pc_inc    = pc + ADDR_W'(1);

    x_micro_sequencer_timer u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (tmr_load),
        .i_load_val (wait_val),
        .i_en       (tmr_en),
        .o_done     (tmr_done)
    );

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        if (i_stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (i_start) state_nxt = S_FETCH;
                S_FETCH: state_nxt = S_EXEC;
                S_EXEC: begin
                    case (cmd)
                        CMD_WAIT: state_nxt = wait_zero ? S_FETCH : S_WAIT;
                        CMD_HALT: state_nxt = S_IDLE;
                        CMD_TRIG: state_nxt = S_TRIG;
                        default:  state_nxt = S_FETCH;
                    endcase
                end
                S_WAIT:  if (tmr_done) state_nxt = S_FETCH;
                S_TRIG:  if (i_trig) state_nxt = S_FETCH;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- output / strobe logic ----------------
    always_comb begin
        o_busy   = (state != S_IDLE);
        o_raddr  = pc;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        out_we   = 1'b0;
        if (!i_stop) begin
            if (state == S_EXEC) begin
                tmr_load = (cmd == CMD_WAIT);
                out_we   = (cmd == CMD_OUT);
            end
            tmr_en = (state == S_WAIT);
        end
    end

    // ---------------- program counter and loop ----------------
    always_comb begin
        pc_nxt = pc;
`ifdef X_MICRO_SEQ_LOOP_EN
        loop_cnt_nxt   = loop_cnt;
        loop_armed_nxt = loop_armed;
`endif
        if (i_stop) begin
`ifdef X_MICRO_SEQ_LOOP_EN
            loop_armed_nxt = 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (i_start) pc_nxt = i_start_addr;
                S_EXEC: begin
                    case (cmd)
                        CMD_WAIT: if (wait_zero) pc_nxt = pc_inc;
                        CMD_JUMP: pc_nxt = tgt;
`ifdef X_MICRO_SEQ_LOOP_EN
                        CMD_LOOP: begin
                            if (!loop_armed) begin
                                // First visit: load the count; a count of 0
                                // falls straight through without arming.
                                loop_cnt_nxt = loop_n;
                                if (loop_n != '0) begin
                                    loop_armed_nxt = 1'b1;
                                    pc_nxt         = tgt;
                                end else begin
                                    loop_armed_nxt = 1'b0;
                                    pc_nxt         = pc_inc;
                                end
                            end else begin
                                loop_cnt_nxt = loop_dec;
                                if (loop_dec != '0) begin
                                    pc_nxt = tgt;
                                end else begin
                                    loop_armed_nxt = 1'b0;
                                    pc_nxt         = pc_inc;
                                end
                            end
                        end
`endif
                        CMD_HALT: pc_nxt = pc;
                        CMD_TRIG: pc_nxt = pc;
                        default:  pc_nxt = pc_inc;
                    endcase
                end
                S_WAIT:  if (tmr_done) pc_nxt = pc_inc;
                S_TRIG:  if (i_trig) pc_nxt = pc_inc;
                default: pc_nxt = pc;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc <= '0;
        end else begin
            pc <= pc_nxt;
        end
    end

`ifdef X_MICRO_SEQ_LOOP_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            loop_cnt   <= '0;
            loop_armed <= 1'b0;
        end else begin
            loop_cnt   <= loop_cnt_nxt;
            loop_armed <= loop_armed_nxt;
        end
    end
`endif

    // ---------------- output word ----------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_data     <= '0;
            o_data_vld <= 1'b0;
        end else begin
            o_data_vld <= out_we;
            if (out_we) begin
                o_data <= i_rdata;
            end
        end
    end

endmodule

// File: tb/tb_x_micro_sequencer_exec.sv
// Bench for x_micro_sequencer_exec. An instruction-level model turns the
// program in the bench RAM into a per-cycle timeline (busy, fetch address,
// output pulses); every cycle the DUT is compared against it, and a few
// literal expectations per test pin the timeline itself.
module tb_x_micro_sequencer_exec;

    localparam int MAXC = 6000;
`ifdef X_MICRO_SEQ_LOOP_EN
    localparam int STOP_OFS = 1100;
`else
    localparam int STOP_OFS = 500;
`endif

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [8:0]  i_start_addr;
    logic        i_stop;
    logic        i_trig;
    logic        o_busy;
    logic [8:0]  o_raddr;
    logic [35:0] i_rdata;
    logic [3:0]  i_rcmd;
    logic [35:0] o_data;
    logic        o_data_vld;

    x_micro_sequencer_exec dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_start_addr (i_start_addr),
        .i_stop       (i_stop),
        .i_trig       (i_trig),
        .o_busy       (o_busy),
        .o_raddr      (o_raddr),
        .i_rdata      (i_rdata),
        .i_rcmd       (i_rcmd),
        .o_data       (o_data),
        .o_data_vld   (o_data_vld)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    bit [39:0]   mem [512];
    logic [39:0] rd_q;
    always @(posedge i_clk) rd_q <= mem[o_raddr];
    assign i_rdata = rd_q[39:4];
    assign i_rcmd  = rd_q[3:0];

    bit          exp_busy [MAXC];
    bit          exp_vld  [MAXC];
    bit [35:0]   exp_dat  [MAXC];
    bit          exp_fv   [MAXC];
    bit [8:0]    exp_fa   [MAXC];

    int          cyc;
    int          n_vec;
    int          n_err;
    logic [35:0] model_data;
    int          obs_c[$];
    logic [35:0] obs_d[$];

    function automatic bit [39:0] w(input bit [3:0] cmd, input bit [35:0] data);
        return {data, cmd};
    endfunction

    function automatic bit [35:0] loop_data(input int tgt, input int n);
        bit [35:0] d;
        d = '0;
        d[8:0]  = 9'(tgt);
        d[24:9] = 16'(n);
        return d;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic mk_busy(input int c, input int cut);
        if (c < cut && c < MAXC) exp_busy[c] = 1'b1;
    endtask

    task automatic mk_fetch(input int c, input int a, input int cut);
        if (c < cut && c < MAXC) begin
            exp_fv[c] = 1'b1;
            exp_fa[c] = 9'(a);
        end
    endtask

    task automatic mk_vld(input int c, input bit [35:0] d, input int cut);
        if (c < cut && c < MAXC) begin
            exp_vld[c] = 1'b1;
            exp_dat[c] = d;
        end
    endtask

    // Program started in cycle s at address sa. Each instruction: fetch in
    // cycle f, execute in f+1, then any stall. Cycles >= cut are dropped
    // (abort/reset). trig_c is the first cycle i_trig is high.
    task automatic build(input int s, input int sa, input int cut, input int trig_c);
        int        f;
        int        pc;
        int        n;
        int        c;
        bit        fin;
        bit [39:0] wd;
        bit [35:0] d;
`ifdef X_MICRO_SEQ_LOOP_EN
        bit        armed;
        int        lcnt;
        armed = 1'b0;
        lcnt  = 0;
`endif
        f   = s + 1;
        pc  = sa;
        fin = 1'b0;
        for (int k = 0; k < 400 && !fin && f + 2 < MAXC; k++) begin
            wd = mem[pc];
            d  = wd[39:4];
            mk_fetch(f, pc, cut);
            mk_busy(f, cut);
            mk_busy(f + 1, cut);
            case (int'(wd[3:0]))
                1: begin mk_vld(f + 2, d, cut); pc = (pc + 1) % 512; f += 2; end
                2: begin
                    n = int'(d[31:0]);
                    for (int j = 0; j < n; j++) mk_busy(f + 2 + j, cut);
                    pc = (pc + 1) % 512;
                    f += 2 + n;
                end
                3: begin pc = int'(d[8:0]); f += 2; end
`ifdef X_MICRO_SEQ_LOOP_EN
                4: begin
                    if (!armed) begin
                        lcnt = int'(d[24:9]);
                        if (lcnt != 0) begin armed = 1'b1; pc = int'(d[8:0]); end
                        else pc = (pc + 1) % 512;
                    end else begin
                        lcnt--;
                        if (lcnt != 0) pc = int'(d[8:0]);
                        else begin armed = 1'b0; pc = (pc + 1) % 512; end
                    end
                    f += 2;
                end
`endif
                5: fin = 1'b1;
                6: begin
                    c = (trig_c > f + 2) ? trig_c : f + 2;
                    for (int j = f + 2; j <= c; j++) mk_busy(j, cut);
                    pc = (pc + 1) % 512;
                    f = c + 1;
                end
                default: begin pc = (pc + 1) % 512; f += 2; end
            endcase
        end
    endtask

    // Compare the current cycle at the falling edge, then advance to just
    // after the next rising edge.
    task automatic tick();
        @(negedge i_clk);
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d got=over want=under %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        if (!i_rst) model_data = '0;
        else if (exp_vld[cyc]) model_data = exp_dat[cyc];
        chk("busy", 64'(o_busy), 64'(exp_busy[cyc]));
        chk("data_vld", 64'(o_data_vld), 64'(exp_vld[cyc]));
        chk("data", 64'(o_data), 64'(model_data));
        if (exp_fv[cyc]) chk("raddr", 64'(o_raddr), 64'(exp_fa[cyc]));
        if (o_data_vld === 1'b1) begin
            obs_c.push_back(cyc);
            obs_d.push_back(o_data);
        end
        @(posedge i_clk);
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic start(input int sa);
        i_start      = 1'b1;
        i_start_addr = 9'(sa);
        tick();
        i_start      = 1'b0;
    endtask

    function automatic int pulses_since(input int c0);
        int n = 0;
        foreach (obs_c[k]) if (obs_c[k] >= c0) n++;
        return n;
    endfunction

    function automatic int nth_cyc(input int c0, input int idx);
        int n = 0;
        foreach (obs_c[k]) if (obs_c[k] >= c0) begin
            if (n == idx) return obs_c[k];
            n++;
        end
        return -1;
    endfunction

    function automatic logic [35:0] nth_dat(input int c0, input int idx);
        int n = 0;
        foreach (obs_c[k]) if (obs_c[k] >= c0) begin
            if (n == idx) return obs_d[k];
            n++;
        end
        return 'x;
    endfunction

    initial begin
        int s;
        int r;
        int bc;

        cyc = 0; n_vec = 0; n_err = 0; model_data = '0;
        i_rst = 1'b0; i_start = 1'b0; i_start_addr = '0; i_stop = 1'b0; i_trig = 1'b0;

        // Power-on reset
        @(posedge i_clk);
        cyc = 1;
        #1;
        run(3);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_raddr", 64'(o_raddr), 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_vld", 64'(o_data_vld), 64'd0);
        i_rst = 1'b1;
        run(2);

        // OUT 0xA, OUT 0xB, HALT from address 0
        mem[0] = w(1, 36'hA);
        mem[1] = w(1, 36'hB);
        mem[2] = w(5, 36'h0);
        s = cyc;
        build(s, 0, MAXC, 0);
        start(0);
        for (int i = 0; i < 10; i++) begin
            if (cyc == s + 6) chk("halt_busy_hi", 64'(o_busy), 64'd1);
            if (cyc == s + 7) chk("halt_busy_lo", 64'(o_busy), 64'd0);
            tick();
        end
        chk("t1_pulses", 64'(pulses_since(s)), 64'd2);
        chk("t1_cyc0", 64'(nth_cyc(s, 0) - s), 64'd3);
        chk("t1_dat0", 64'(nth_dat(s, 0)), 64'hA);
        chk("t1_cyc1", 64'(nth_cyc(s, 1) - s), 64'd5);
        chk("t1_dat1", 64'(nth_dat(s, 1)), 64'hB);

        // OUT 1, WAIT 5, OUT 2, HALT; a second start during the wait is ignored
        mem[10] = w(1, 36'h1);
        mem[11] = w(2, 36'd5);
        mem[12] = w(1, 36'h2);
        mem[13] = w(5, 36'h0);
        s = cyc;
        build(s, 10, MAXC, 0);
        start(10);
        for (int i = 0; i < 20; i++) begin
            if (i == 6) begin i_start = 1'b1; i_start_addr = 9'd0; end
            else i_start = 1'b0;
            tick();
        end
        // WAIT occupies 2+5 cycles, plus 2 for the second OUT
        chk("t2_gap", 64'(nth_cyc(s, 1) - nth_cyc(s, 0)), 64'd9);
        chk("t2_dat1", 64'(nth_dat(s, 1)), 64'h2);
        chk("t2_pulses", 64'(pulses_since(s)), 64'd2);

        // JUMP 511, NOP at 511 wraps to HALT at 0
        mem[40]  = w(3, 36'd511);
        mem[511] = w(0, 36'h0);
        mem[0]   = w(5, 36'h0);
        s = cyc;
        build(s, 40, MAXC, 0);
        start(40);
        bc = 0;
        for (int i = 0; i < 10; i++) begin
            if (cyc == s + 5) chk("wrap_raddr", 64'(o_raddr), 64'd0);
            bc += int'(o_busy);
            tick();
        end
        chk("wrap_busy_cycles", 64'(bc), 64'd6);

        // Loop body OUT 0x33, LOOP target=60 N=3
        mem[60] = w(1, 36'h33);
        mem[61] = w(4, loop_data(60, 3));
        mem[62] = w(5, 36'h0);
        s = cyc;
        build(s, 60, MAXC, 0);
        start(60);
        run(24);
`ifdef X_MICRO_SEQ_LOOP_EN
        chk("loop_pulses", 64'(pulses_since(s)), 64'd4);
`else
        chk("loop_pulses", 64'(pulses_since(s)), 64'd1);
`endif

        // TRIG with i_trig low 10 cycles in TRIG, then high
        mem[80] = w(6, 36'h0);
        mem[81] = w(1, 36'h44);
        mem[82] = w(5, 36'h0);
        s = cyc;
        r = s + 13;
        build(s, 80, MAXC, r);
        start(80);
        for (int i = 0; i < 22; i++) begin
            if (cyc == r) i_trig = 1'b1;
            tick();
        end
        chk("trig_out_cyc", 64'(nth_cyc(s, 0) - r), 64'd3);
        chk("trig_out_dat", 64'(nth_dat(s, 0)), 64'h44);

        // TRIG with i_trig already high on entry
        mem[90] = w(6, 36'h0);
        mem[91] = w(1, 36'h45);
        mem[92] = w(5, 36'h0);
        s = cyc;
        build(s, 90, MAXC, 0);
        start(90);
        run(10);
        i_trig = 1'b0;
        chk("trig_hi_cyc", 64'(nth_cyc(s, 0) - s), 64'd6);

        // start and stop together in IDLE: stop wins
        i_start = 1'b1; i_stop = 1'b1; i_start_addr = 9'd10;
        tick();
        i_start = 1'b0; i_stop = 1'b0;
        chk("start_stop_idle", 64'(o_busy), 64'd0);
        run(3);

        // Stop during WAIT 1000 (loop armed with the loop build), then restart
        mem[100] = w(1, 36'h55);
        mem[101] = w(2, 36'd1000);
        mem[102] = w(4, loop_data(100, 1));
        mem[103] = w(5, 36'h0);
        s = cyc;
        r = s + STOP_OFS;
        build(s, 100, r + 1, 0);
        start(100);
        while (cyc < r) tick();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        chk("stop_busy", 64'(o_busy), 64'd0);
        chk("stop_data_held", 64'(o_data), 64'h55);
        run(4);
        s = cyc;
        build(s, 100, MAXC, 0);
        start(100);
        run(2100);
        chk("restart_idle", 64'(o_busy), 64'd0);
`ifdef X_MICRO_SEQ_LOOP_EN
        chk("restart_pulses", 64'(pulses_since(s)), 64'd2);
`else
        chk("restart_pulses", 64'(pulses_since(s)), 64'd1);
`endif

        // Async reset mid-program
        mem[120] = w(1, 36'h66);
        mem[121] = w(2, 36'd50);
        mem[122] = w(5, 36'h0);
        s = cyc;
        r = s + 10;
        build(s, 120, r, 0);
        start(120);
        while (cyc < r) tick();
        i_rst = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(o_busy), 64'd0);
        chk("mid_rst_raddr", 64'(o_raddr), 64'd0);
        chk("mid_rst_data", 64'(o_data), 64'd0);
        chk("mid_rst_vld", 64'(o_data_vld), 64'd0);
        run(3);
        i_rst = 1'b1;
        run(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
